// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op codes, FSM states,
// flag bit positions inside RSP_FLAGS and the ALU data width.
package alu_share_arbiter_pkg;

  localparam int ALU_W   = 32;
  localparam int FLAGS_W = 4;

  // ALU operation codes carried on REQ_SELECT
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Bit positions of {Z,N,V,C} in RSP_FLAGS
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes with SELECT[1] set are treated as logic ops: no carry, no overflow.
  function automatic logic alu_is_logic(input logic [2:0] sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Shared 32-bit ALU: ADD/SUB/AND/OR/SLT with {Z,N,V,C} flags. Purely
// combinational; the caller registers result and flags.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        is_logic;

  // Single adder serves ADD, SUB and SLT; SELECT[0] selects B inversion and carry-in
  always_comb begin
    is_logic = alu_is_logic(sel);
    b_eff    = sel[0] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, sel[0]};
    case (sel)
      ALU_ADD, ALU_SUB: result = sum[31:0];
      ALU_AND:          result = a & b;
      ALU_OR:           result = a | b;
      ALU_SLT:          result = {31'd0, sum[31]};
      default:          result = '0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == 32'd0);
    flags[FLAG_N] = result[31];
    flags[FLAG_V] = ~is_logic & (a[31] == b_eff[31]) & (sum[31] != a[31]);
    flags[FLAG_C] = ~is_logic & sum[32];
  end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// wrapping modulo N_REQ; returns a one-hot grant, its index and a hit flag.
module alu_share_arbiter_rr #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               j;
  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the first requester after ptr wins last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = j[IDX_W-1:0];
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters. IDLE grants a round-robin winner
// and latches its operands, EXEC registers the ALU result and flags, RESP
// holds the response to the owner until it is accepted.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_REQ-1:0]     REQ_VALID,
  output logic [N_REQ-1:0]     REQ_READY,
  input  logic [32*N_REQ-1:0]  REQ_DATA1,
  input  logic [32*N_REQ-1:0]  REQ_DATA2,
  input  logic [3*N_REQ-1:0]   REQ_SELECT,
  output logic [N_REQ-1:0]     RSP_VALID,
  input  logic [N_REQ-1:0]     RSP_READY,
  output logic [31:0]          RSP_RESULT,
  output logic [3:0]           RSP_FLAGS,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     OP_COUNT
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] ptr_nxt;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_valid;
  logic [31:0]      alu_res;
  logic [3:0]       alu_flags;

  alu_share_arbiter_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (REQ_VALID),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  alu_share_arbiter_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Pointer moves to the requester just after the winner, wrapping at N_REQ
  always_comb begin
    if (gnt_idx == IDX_W'(N_REQ - 1)) ptr_nxt = '0;
    else                              ptr_nxt = gnt_idx + 1'b1;
  end

  // Next-state, datapath capture and handshake outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    res_d     = res_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        // A grant always completes the handshake since READY follows the winner
        if (gnt_any) begin
          req_ready = gnt;
          a_d       = REQ_DATA1[32*gnt_idx +: 32];
          b_d       = REQ_DATA2[32*gnt_idx +: 32];
          sel_d     = REQ_SELECT[3*gnt_idx +: 3];
          owner_d   = gnt_idx;
          ptr_d     = ptr_nxt;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        flags_d = alu_flags;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (RSP_READY[owner_q]) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // READY is masked while RESET is held so no grant is visible during reset
  assign REQ_READY  = RESET ? '0 : req_ready;
  assign RSP_VALID  = rsp_valid;
  assign RSP_RESULT = res_q;
  assign RSP_FLAGS  = flags_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign OP_COUNT   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table of single ops with
// hand-computed results/flags, then round-robin, back-pressure and reset
// sequences.
module tb_alu_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_data1;
  logic [32*N-1:0] req_data2;
  logic [3*N-1:0]  req_select;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic            busy;
  logic [15:0]     op_count;

  int tests  = 0;
  int failed = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(4), .IDX_W(2), .CNT_W(16)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_DATA1  (req_data1),
    .REQ_DATA2  (req_data2),
    .REQ_SELECT (req_select),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_RESULT (rsp_result),
    .RSP_FLAGS  (rsp_flags),
    .BUSY       (busy),
    .OP_COUNT   (op_count)
  );

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One isolated op from requester r, checked cycle by cycle
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_valid = '0;
    req_valid[v.r] = 1'b1;
    req_data1[32*v.r +: 32] = v.a;
    req_data2[32*v.r +: 32] = v.b;
    req_select[3*v.r +: 3]  = v.sel;
    #1 chk("grant", 32'(req_ready), 32'(1 << v.r));
    @(posedge clk);
    #1 req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 chk("rsp_valid", 32'(rsp_valid), 32'(1 << v.r));
    chk("result", rsp_result, v.exp_res);
    chk("flags", 32'(rsp_flags), 32'(v.exp_flags));
    rsp_ready = '0;
    rsp_ready[v.r] = 1'b1;
    @(posedge clk);
    #1 exp_cnt++;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("idle", 32'(busy), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    rsp_ready = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_result"}, rsp_result, 32'd0);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    // {Z,N,V,C}
    vecs[0]  = '{0, 32'd5,          32'd3,          3'b000, 32'd8,          4'b0000};
    vecs[1]  = '{1, 32'd7,          32'd7,          3'b001, 32'd0,          4'b1001};
    vecs[2]  = '{1, 32'd3,          32'd5,          3'b101, 32'd1,          4'b0000};
    vecs[3]  = '{2, 32'h7FFFFFFF,   32'd1,          3'b000, 32'h80000000,   4'b0110};
    vecs[4]  = '{2, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b010, 32'h00F000F0,   4'b0000};
    vecs[5]  = '{3, 32'hF0000000,   32'h0000000F,   3'b011, 32'hF000000F,   4'b0100};
    vecs[6]  = '{3, 32'd0,          32'd1,          3'b001, 32'hFFFFFFFF,   4'b0100};
    vecs[7]  = '{0, 32'd5,          32'd3,          3'b101, 32'd0,          4'b1001};
    vecs[8]  = '{1, 32'd1,          32'd2,          3'b100, 32'd0,          4'b1000};
    vecs[9]  = '{2, 32'hFFFFFFFF,   32'd1,          3'b000, 32'd0,          4'b1001};
    vecs[10] = '{3, 32'h80000000,   32'd1,          3'b001, 32'h7FFFFFFF,   4'b0011};

    req_valid  = '1;
    req_data1  = '0;
    req_data2  = '0;
    req_select = '0;
    rsp_ready  = '0;
    rst        = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_hold");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Round robin: everyone valid, responses always accepted
    for (int i = 0; i < N; i++) begin
      req_data1[32*i +: 32] = 32'(i + 1);
      req_data2[32*i +: 32] = 32'd10;
      req_select[3*i +: 3]  = 3'b000;
    end
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % N;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << e));
      @(posedge clk);
      #1 chk("rr_exec_no_grant", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 chk("rr_owner", 32'(rsp_valid), 32'(1 << e));
      chk("rr_result", rsp_result, 32'(e + 11));
      @(posedge clk);
      exp_cnt++;
    end
    #1 chk("rr_count", 32'(op_count), 32'(exp_cnt));

    // Back-pressure: owner 2 withholds RSP_READY, non-owners offer it
    rsp_ready = 4'b1011;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0100);
    repeat (2) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
      chk("bp_result", rsp_result, 32'd13);
      chk("bp_flags", 32'(rsp_flags), 32'd0);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      chk("bp_count", 32'(op_count), 32'(exp_cnt));
      @(posedge clk);
    end
    #1 rsp_ready = 4'b0100;
    @(posedge clk);
    #1 exp_cnt++;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_count_after", 32'(op_count), 32'(exp_cnt));
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    rsp_ready = '0;

    // Reset in EXEC: requester 3 was just accepted
    @(posedge clk);
    #1 chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_grant", 32'(req_ready), 32'b0001);
    chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = '1;
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 chk("post_reset_owner", 32'(rsp_valid), 32'b0001);
    chk("post_reset_result", rsp_result, 32'd11);
    @(posedge clk);
    #1 chk("post_reset_count", 32'(op_count), 32'd1);
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
